// File: rtl/piso_shift_stream.sv
// Parallel-in/serial-out shifter with a valid/ready load handshake.
// Streams WIDTH-bit words one bit at a time, each bit held BIT_CYCLES clocks, with no gap between words.
module piso_shift_stream #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int BIT_CYCLES = 1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [CW-1:0]    cyc_cnt;
   logic             cyc_wrap;
   logic             final_slot;
   logic             accept;

   function automatic logic first_bit(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-1] : word[0];
   endfunction

   // Bit that becomes current once the register advances by one position.
   function automatic logic next_bit(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? word[WIDTH-2] : word[1];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
      return MSB_FIRST ? (word << 1) : (word >> 1);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cyc_wrap   = (cyc_cnt == CYC_LAST);
      final_slot = (state == SHIFT) && (bit_cnt == BIT_LAST) && cyc_wrap;
      in_ready   = (state == IDLE) || final_slot;
      accept     = in_valid && in_ready;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (final_slot && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // An accept in the final slot reloads directly, so the next word follows without a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         cyc_cnt   <= '0;
         ser_out   <= IDLE_LEVEL;
         ser_valid <= 1'b0;
         last_bit  <= 1'b0;
      end else if (accept) begin
         shreg     <= in_data;
         bit_cnt   <= '0;
         cyc_cnt   <= '0;
         ser_out   <= first_bit(in_data);
         ser_valid <= 1'b1;
         last_bit  <= 1'b0;
      end else if (state == SHIFT) begin
         if (final_slot) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            last_bit  <= 1'b0;
         end else if (cyc_wrap) begin
            shreg    <= advance(shreg);
            ser_out  <= next_bit(shreg);
            bit_cnt  <= bit_cnt + BW'(1);
            cyc_cnt  <= '0;
            last_bit <= (bit_cnt == BIT_PEN);
         end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
         end
      end
   end

   assign busy = ser_valid;

endmodule
